// File: rtl/uart_pkg.sv
// Shared UART definitions: default word/FIFO sizes, pointer-width helper and
// the transmitter state encoding reused across UART blocks.
package uart_pkg;

  localparam int unsigned DATA_LENGTH = 8;
  localparam int unsigned FIFO_DEPTH  = 16;

  // Pointer carries one extra wrap bit above the storage index.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Depth x DataLength storage: one clocked write port, one asynchronous read port.
// No reset; contents are undefined until written.
module uart_fifo_mem #(
  parameter int unsigned DataLength = 8,
  parameter int unsigned Depth      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_write_en,
  input  logic [$clog2(Depth)-1:0] i_write_addr,
  input  logic [DataLength-1:0]    i_data,
  input  logic [$clog2(Depth)-1:0] i_read_addr,
  output logic [DataLength-1:0]    o_data
);

  logic [DataLength-1:0] mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_write_en) mem[i_write_addr] <= i_data;
  end

  assign o_data = mem[i_read_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO feeding the UART transmitter.
// Optional sticky overflow/underflow flags when UART_TX_FIFO_ERR_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DataLength      = DATA_LENGTH,
  parameter int unsigned Depth           = FIFO_DEPTH,
  parameter int unsigned AlmostFullLevel = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_write_en,
  input  logic [DataLength-1:0]      i_data,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic [DataLength-1:0]      o_data,
  output logic                       o_empty,
  input  logic                       i_read_en,
`ifdef UART_TX_FIFO_ERR_EN
  input  logic                       i_err_clr,
  output logic                       o_overflow,
  output logic                       o_underflow,
`endif
  output logic [$clog2(Depth):0]     o_count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = ptr_width(Depth);

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          wr_fire, rd_fire;

  // Flags come only from registered pointers, so strobes never reach them combinationally.
  assign o_empty       = (wr_ptr == rd_ptr);
  assign o_full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign o_almost_full = (count >= PW'(AlmostFullLevel));
  assign o_count       = count;

  assign wr_fire = i_write_en & ~o_full;
  assign rd_fire = i_read_en  & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  uart_fifo_mem #(
    .DataLength(DataLength),
    .Depth     (Depth)
  ) u_mem (
    .i_clk       (i_clk),
    .i_write_en  (wr_fire),
    .i_write_addr(wr_ptr[AW-1:0]),
    .i_data      (i_data),
    .i_read_addr (rd_ptr[AW-1:0]),
    .o_data      (o_data)
  );

`ifdef UART_TX_FIFO_ERR_EN
  // Set term is OR-ed after the clear so a coincident new error keeps the flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (i_write_en & o_full)  | (o_overflow  & ~i_err_clr);
      o_underflow <= (i_read_en  & o_empty) | (o_underflow & ~i_err_clr);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (Depth=16, AlmostFullLevel=12).
// Error-flag scenario is built only when UART_TX_FIFO_ERR_EN is defined.
module tb_uart_tx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_write_en;
  logic [7:0] i_data;
  logic       o_full;
  logic       o_almost_full;
  logic [7:0] o_data;
  logic       o_empty;
  logic       i_read_en;
  logic [4:0] o_count;
`ifdef UART_TX_FIFO_ERR_EN
  logic       i_err_clr;
  logic       o_overflow;
  logic       o_underflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  uart_tx_fifo #(
    .DataLength     (8),
    .Depth          (16),
    .AlmostFullLevel(12)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_write_en   (i_write_en),
    .i_data       (i_data),
    .o_full       (o_full),
    .o_almost_full(o_almost_full),
    .o_data       (o_data),
    .o_empty      (o_empty),
    .i_read_en    (i_read_en),
`ifdef UART_TX_FIFO_ERR_EN
    .i_err_clr    (i_err_clr),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow),
`endif
    .o_count      (o_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_write_en = 1'b0; i_read_en = 1'b0; i_data = '0;
`ifdef UART_TX_FIFO_ERR_EN
    i_err_clr = 1'b0;
`endif
    step(); step();
    checks++;
    if (o_empty !== 1'b1 || o_full !== 1'b0 || o_almost_full !== 1'b0 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL reset: empty=%b full=%b afull=%b count=%0d, required 1 0 0 0",
               o_empty, o_full, o_almost_full, o_count);
    end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    i_write_en = 1'b1; i_data = 8'hA5;
    step();
    i_write_en = 1'b0;
    checks++;
    if (o_empty !== 1'b0 || o_data !== 8'hA5 || o_count !== 5'd1) begin
      errors++;
      $display("FAIL single_write: empty=%b data=%h count=%0d, required 0 a5 1", o_empty, o_data, o_count);
    end
    i_read_en = 1'b1;
    step();
    i_read_en = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL single_read: empty=%b count=%0d, required 1 0", o_empty, o_count);
    end
  endtask

  task automatic test_fill();
    for (int unsigned i = 0; i < 16; i++) begin
      i_write_en = 1'b1; i_data = 8'(i);
      step();
      checks++;
      if (o_count !== 5'(i + 1) || o_almost_full !== (i + 1 >= 12) || o_full !== (i + 1 == 16)) begin
        errors++;
        $display("FAIL fill[%0d]: count=%0d afull=%b full=%b, required %0d %b %b",
                 i, o_count, o_almost_full, o_full, i + 1, (i + 1 >= 12), (i + 1 == 16));
      end
    end
    i_data = 8'hFF;
    step();
    i_write_en = 1'b0;
    checks++;
    if (o_count !== 5'd16 || o_full !== 1'b1 || o_data !== 8'h00) begin
      errors++;
      $display("FAIL overfill_drop: count=%0d full=%b head=%h, required 16 1 00", o_count, o_full, o_data);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      checks++;
      if (o_data !== 8'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: data=%h, required %h", i, o_data, 8'(i));
      end
      i_read_en = 1'b1;
      step();
    end
    i_read_en = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL drain_end: empty=%b count=%0d, required 1 0", o_empty, o_count);
    end
  endtask

  // Two primed words, then 38 simultaneous write+read beats across the pointer wrap.
  task automatic test_wrap();
    logic [7:0] exp_head;
    i_write_en = 1'b1;
    i_data = 8'h40; step();
    i_data = 8'h41; step();
    for (int unsigned k = 0; k < 38; k++) begin
      i_data = 8'(8'h42 + k);
      i_read_en = 1'b1;
      step();
      exp_head = 8'(8'h41 + k);
      checks++;
      if (o_data !== exp_head || o_full !== 1'b0 || o_count !== 5'd2) begin
        errors++;
        $display("FAIL wrap[%0d]: data=%h full=%b count=%0d, required %h 0 2",
                 k, o_data, o_full, o_count, exp_head);
      end
    end
    i_write_en = 1'b0;
    step();
    checks++;
    if (o_data !== 8'h67 || o_count !== 5'd1) begin
      errors++;
      $display("FAIL wrap_tail: data=%h count=%0d, required 67 1", o_data, o_count);
    end
    step();
    i_read_en = 1'b0;
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_empty: empty=%b, required 1", o_empty);
    end
  endtask

  task automatic test_full_rw();
    i_write_en = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      i_data = 8'(8'h80 + i);
      step();
    end
    i_data = 8'hEE; i_read_en = 1'b1;
    step();
    i_write_en = 1'b0; i_read_en = 1'b0;
    checks++;
    if (o_count !== 5'd15 || o_data !== 8'h81 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: count=%0d data=%h full=%b, required 15 81 0", o_count, o_data, o_full);
    end
    for (int unsigned i = 1; i < 16; i++) begin
      checks++;
      if (o_data !== 8'(8'h80 + i)) begin
        errors++;
        $display("FAIL full_rw_drain[%0d]: data=%h, required %h", i, o_data, 8'(8'h80 + i));
      end
      i_read_en = 1'b1;
      step();
    end
    i_read_en = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL full_rw_end: empty=%b count=%0d, required 1 0", o_empty, o_count);
    end
  endtask

  task automatic test_empty_rw_and_reset();
    i_write_en = 1'b1; i_read_en = 1'b1; i_data = 8'h3C;
    step();
    i_read_en = 1'b0;
    checks++;
    if (o_count !== 5'd1 || o_data !== 8'h3C || o_empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw: count=%0d data=%h empty=%b, required 1 3c 0", o_count, o_data, o_empty);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      i_data = 8'(8'h10 + i);
      step();
    end
    i_write_en = 1'b0;
    checks++;
    if (o_count !== 5'd5) begin
      errors++;
      $display("FAIL pre_reset: count=%0d, required 5", o_count);
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (o_empty !== 1'b1 || o_count !== 5'd0 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: empty=%b count=%0d full=%b, required 1 0 0", o_empty, o_count, o_full);
    end
    step();
    i_rst = 1'b0;
    step();
  endtask

`ifdef UART_TX_FIFO_ERR_EN
  task automatic test_err();
    i_write_en = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      i_data = 8'(i);
      step();
    end
    step();
    i_write_en = 1'b0;
    step();
    checks++;
    if (o_overflow !== 1'b1 || o_underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b unf=%b, required 1 0", o_overflow, o_underflow);
    end
    i_write_en = 1'b1; i_err_clr = 1'b1;
    step();
    i_write_en = 1'b0; i_err_clr = 1'b0;
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set_wins: ovf=%b, required 1", o_overflow);
    end
    i_read_en = 1'b1;
    for (int unsigned i = 0; i < 17; i++) step();
    i_read_en = 1'b0;
    checks++;
    if (o_underflow !== 1'b1 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: unf=%b empty=%b, required 1 1", o_underflow, o_empty);
    end
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    checks++;
    if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: ovf=%b unf=%b, required 0 0", o_overflow, o_underflow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_full_rw();
    test_empty_rw_and_reset();
`ifdef UART_TX_FIFO_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synchronous first-word-fall-through (FWFT) FIFO that buffers host bytes ahead of the UART transmitter.
- Host writes bytes on the write side.
- The transmitter sees the head byte continuously on o_data, together with o_empty.
- The transmitter pops the head byte with a one-cycle i_read_en pulse.
- Both sides run on the transmitter's oversampled clock domain; there is no CDC inside this block.

Parameters:
- DataLength, 8, width of one data word in bits.
- Depth, 16, number of entries; must be a power of two and ≥ 2.
- AlmostFullLevel, 12, o_almost_full asserts when occupancy ≥ this value; legal range 1..Depth.

Ports:
- i_clk  input  1  clock; same clock as the transmitter.
- i_rst  input  1  asynchronous reset, active-high.
- i_write_en  input  1  host write strobe; one word per cycle while high.
- i_data  input  DataLength  host write data, sampled when i_write_en=1.
- o_full  output  1  no free entry.
- o_almost_full  output  1  occupancy ≥ AlmostFullLevel.
- o_data  output  DataLength  head word (FWFT); valid while o_empty=0.
- o_empty  output  1  no stored entry.
- i_read_en  input  1  pop strobe from the transmitter.
- o_count  output  $clog2(Depth)+1  current occupancy, 0..Depth.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, rd_ptr=0, count=0.
  - o_empty=1, o_full=0, o_almost_full=0, o_count=0.
  - o_data is don't-care; storage is not cleared.
  - Reset mid-operation discards all contents immediately.
- Pointers:
  - Width $clog2(Depth)+1; the MSB is the wrap bit.
  - Storage index is the low $clog2(Depth) bits; the index wraps naturally from Depth-1 to 0.
  - full ⇔ index bits are equal and MSBs differ.
  - empty ⇔ pointers are fully equal.
- Write accepted (wr_fire) ⇔ i_write_en & !o_full.
  - On wr_fire: mem[wr_idx] <= i_data; wr_ptr += 1.
  - Write while full: dropped; no state change.
- Read accepted (rd_fire) ⇔ i_read_en & !o_empty.
  - On rd_fire: rd_ptr += 1.
  - Read while empty: ignored; no state change.
- o_data is a combinational read of mem[rd_idx].
  - A word written into an empty FIFO appears on o_data, with o_empty=0, on the cycle after the write edge (1-cycle latency).
- Simultaneous wr_fire and rd_fire: both pointers advance; count unchanged.
- Write+read while full: the read pops, but the write is dropped, because full is evaluated before the edge.
- Write+read while empty: the write is accepted and the read is ignored; count becomes 1.
- count register: +1 on wr_fire only, -1 on rd_fire only, otherwise held.
- o_full, o_empty, o_almost_full and o_count are all derived from registered state (no combinational path from i_write_en/i_read_en).
- o_data remains stable between pops, as required by a transmitter that indexes bits of o_data across a whole frame.

Optional Feature:
Macro UART_TX_FIFO_ERR_EN.
- Defined: adds ports i_err_clr (input, 1), o_overflow (output, 1) and o_underflow (output, 1).
  - o_overflow sets on i_write_en & o_full.
  - o_underflow sets on i_read_en & o_empty.
  - Both flags are sticky until a cycle with i_err_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - Both flags reset to 0.
- Not defined: the ports and logic are absent; illegal accesses are silently dropped as above.

Decomposition:
- Shared package uart_pkg:
  - DataLength default.
  - FIFO depth default.
  - Pointer-width localparam helper expression.
  - Transmitter state enum, for reuse by the transmitter and other UART blocks.
- One sub-module: uart_fifo_mem.
  - Storage array, Depth × DataLength.
  - Single write port: clocked, with write enable.
  - One asynchronous read port.
  - No reset.
- Pointer, count and flag logic stay in uart_tx_fifo.

Test Plan:
- Reset, then write 0xA5 at cycle 0 → cycle 1: o_empty=0, o_data=0xA5, o_count=1; pulse i_read_en → next cycle o_empty=1, o_count=0.
- Write 0x00..0x0F (Depth=16) → o_full=1 after the 16th write; o_almost_full=1 from o_count=12; a 17th write of 0xFF is dropped; reading all 16 returns 0x00..0x0F in order.
- Wrap-around: interleave 40 writes and reads keeping occupancy 1..3 → data order preserved across pointer wrap; o_full never asserts.
- When full, assert i_write_en and i_read_en together → o_count 16→15; head advances; the written word is absent.
- When empty, assert i_write_en and i_read_en together with 0x3C → o_count=1, o_data=0x3C next cycle; then assert i_rst mid-stream with 5 entries → o_empty=1, o_count=0 immediately (async).
- With UART_TX_FIFO_ERR_EN: write when full → o_overflow=1 and holds; read when empty → o_underflow=1; i_err_clr coincident with a new overflow → o_overflow stays 1; a clean i_err_clr → both 0.
